reg_blk: RTL and testbench

//   Instruction register plus 8-entry general-purpose register file for the

---
 rtl/reg_blk.sv | 74 +++++++
 tb/tb_reg_blk.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_blk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_blk                                                         |
// | Purpose  : Instruction register, field decode, 8-entry register file and   |
// |            Z/N flags derived from R1.                                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reg_blk #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              ir_load,
    input  logic [DATA_W-1:0] instruction,
    input  logic              wb,
    input  logic [DATA_W-1:0] wbvalue,
    output logic [1:0]        opcode,
    output logic [2:0]        oprand,
    output logic [2:0]        ra_sel,
    output logic [2:0]        rb_sel,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb,
    output logic [DATA_W-1:0] r1,
    output logic              z_flag,
    output logic              n_flag
);

    localparam int         c_NREGS  = 8;
    localparam logic [1:0] c_OP_ALU = 2'b11;

    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_regs [c_NREGS];

    logic [1:0] w_opcode;
    logic [2:0] w_ra_sel;
    logic [2:0] w_rb_sel;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_ir <= '0;
        end else if (ir_load) begin
            r_ir <= instruction;
        end
    end

    // The write index comes from the IR as it stood before this edge, so a
    // simultaneous ir_load does not redirect the write.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb) begin
            r_regs[w_rb_sel] <= wbvalue;
        end
    end

    assign w_opcode = r_ir[7:6];
    assign w_ra_sel = r_ir[5:3];
    assign w_rb_sel = r_ir[2:0];

    assign opcode = w_opcode;
    assign oprand = (w_opcode == c_OP_ALU) ? w_ra_sel : 3'b000;
    assign ra_sel = w_ra_sel;
    assign rb_sel = w_rb_sel;

    assign ra     = r_regs[w_ra_sel];
    assign rb     = r_regs[w_rb_sel];
    assign r1     = r_regs[1];
    assign z_flag = (r_regs[1] == '0);
    assign n_flag = r_regs[1][DATA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_reg_blk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_blk                                                      |
// | Purpose  : Directed self-checking bench for reg_blk.                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_reg_blk;

    logic       clk;
    logic       rst_bar;
    logic       ir_load;
    logic [7:0] instruction;
    logic       wb;
    logic [7:0] wbvalue;
    logic [1:0] opcode;
    logic [2:0] oprand;
    logic [2:0] ra_sel;
    logic [2:0] rb_sel;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] r1;
    logic       z_flag;
    logic       n_flag;

    int total = 0;
    int bad   = 0;

    reg_blk #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_bar     (rst_bar),
        .ir_load     (ir_load),
        .instruction (instruction),
        .wb          (wb),
        .wbvalue     (wbvalue),
        .opcode      (opcode),
        .oprand      (oprand),
        .ra_sel      (ra_sel),
        .rb_sel      (rb_sel),
        .ra          (ra),
        .rb          (rb),
        .r1          (r1),
        .z_flag      (z_flag),
        .n_flag      (n_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [7:0] ins);
        ir_load     = 1'b1;
        instruction = ins;
        tick();
        ir_load     = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] idx, input logic [7:0] val);
        load_ir({5'b00_000, idx});
        wb      = 1'b1;
        wbvalue = val;
        tick();
        wb      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_opcode"}, opcode, 2'b00);
        check({tag, "_oprand"}, oprand, 3'b000);
        check({tag, "_ra_sel"}, ra_sel, 3'b000);
        check({tag, "_rb_sel"}, rb_sel, 3'b000);
        check({tag, "_ra"},     ra,     8'h00);
        check({tag, "_rb"},     rb,     8'h00);
        check({tag, "_r1"},     r1,     8'h00);
        check({tag, "_z"},      z_flag, 1'b1);
        check({tag, "_n"},      n_flag, 1'b0);
    endtask

    initial begin
        rst_bar     = 1'b0;
        ir_load     = 1'b0;
        instruction = 8'h00;
        wb          = 1'b0;
        wbvalue     = 8'h00;
        #2;
        check_reset_outputs("por");
        tick();
        rst_bar = 1'b1;

        // Decode of an ALU instruction and a LOAD instruction
        load_ir(8'b11_001_010);
        check("alu_opcode", opcode, 2'b11);
        check("alu_oprand", oprand, 3'b001);
        check("alu_rb_sel", rb_sel, 3'b010);
        load_ir(8'b01_101_011);
        check("ld_opcode", opcode, 2'b01);
        check("ld_oprand", oprand, 3'b000);
        check("ld_ra_sel", ra_sel, 3'b101);
        check("ld_rb_sel", rb_sel, 3'b011);

        // R1 flags
        write_reg(3'd1, 8'h80);
        check("r1_80",   r1,     8'h80);
        check("n_80",    n_flag, 1'b1);
        check("z_80",    z_flag, 1'b0);
        check("rb_r1",   rb,     8'h80);
        write_reg(3'd1, 8'h00);
        check("r1_00",   r1,     8'h00);
        check("z_00",    z_flag, 1'b1);
        check("n_00",    n_flag, 1'b0);

        // Simultaneous ir_load and wb: write goes to the old rb_sel (3)
        load_ir(8'b00_000_011);
        ir_load     = 1'b1;
        instruction = 8'b00_000_101;
        wb          = 1'b1;
        wbvalue     = 8'h5A;
        tick();
        ir_load = 1'b0;
        wb      = 1'b0;
        check("same_rb_sel", rb_sel, 3'b101);
        check("same_reg5",   rb,     8'h00);
        load_ir(8'b00_000_011);
        check("same_reg3",   rb,     8'h5A);

        // Fill all registers, including R0
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 8'h10 + 8'(i));
        end
        load_ir(8'b00_110_010);
        check("fill_ra", ra, 8'h16);
        check("fill_rb", rb, 8'h12);
        check("fill_r1", r1, 8'h11);
        check("fill_z",  z_flag, 1'b0);
        load_ir(8'b00_000_111);
        check("fill_r0", ra, 8'h10);
        check("fill_r7", rb, 8'h17);

        // No bypass: pending write not visible until the edge
        load_ir(8'b00_000_010);
        wb      = 1'b1;
        wbvalue = 8'h77;
        #3;
        check("nobyp_pre",  rb, 8'h12);
        tick();
        wb = 1'b0;
        check("nobyp_post", rb, 8'h77);

        // Async reset mid-cycle with wb and ir_load held
        load_ir(8'b01_011_001);
        wb          = 1'b1;
        wbvalue     = 8'h99;
        ir_load     = 1'b1;
        instruction = 8'hFF;
        #2;
        rst_bar = 1'b0;
        #1;
        check_reset_outputs("mid");
        tick();
        check_reset_outputs("held");
        ir_load = 1'b0;
        #2;
        rst_bar = 1'b1;
        #1;
        check("rel_pre_rb", rb, 8'h00);
        tick();
        wb = 1'b0;
        check("rel_rb",  rb, 8'h99);
        check("rel_ra",  ra, 8'h99);
        check("rel_r1",  r1, 8'h00);
        check("rel_op",  opcode, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
